// File: rtl/transpose_skew_feeder.sv
// Row feeder for a skew-based matrix transpose: tags each row with its index and circular-shift amount.
// One cycle from input transfer to out_valid; a 2-deep buffer absorbs one cycle of downstream stall.

// Generic synchronous FIFO; head is visible combinationally on rd_dat.
// Latency: written entry is visible the cycle after push; backpressure: caller gates push on count < DEPTH.
module transpose_skew_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Tags rows with index/shift, buffers them 2 deep and tracks matrix progress.
// Latency 1 cycle when empty; in_ready drops when the buffer is full or abort is high.
module transpose_skew_feeder #(
  parameter int TOTAL_WIDTH    = 512,
  parameter int ELEM_WIDTH     = 32,
  parameter int NUM_ELEMS      = TOTAL_WIDTH / ELEM_WIDTH,
  parameter int SHIFT_AMT_BITS = $clog2(TOTAL_WIDTH),
  parameter int ROW_IDX_BITS   = $clog2(NUM_ELEMS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TOTAL_WIDTH-1:0]    in_row,
  input  logic                      skew_dir,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TOTAL_WIDTH-1:0]    out_row,
  output logic [SHIFT_AMT_BITS-1:0] out_shift_amt,
  output logic [ROW_IDX_BITS-1:0]   out_row_idx,
  output logic                      out_last,
  output logic                      matrix_done,
  output logic                      busy
);
  localparam int unsigned NE = NUM_ELEMS;
  localparam int unsigned EW = ELEM_WIDTH;

  typedef struct packed {
    logic [TOTAL_WIDTH-1:0]    row;
    logic [SHIFT_AMT_BITS-1:0] shift_amt;
    logic [ROW_IDX_BITS-1:0]   row_idx;
    logic                      last;
  } entry_t;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state, state_nxt;
  logic [ROW_IDX_BITS-1:0] row_cnt, row_cnt_nxt;
  logic                    dir_q, dir_nxt, cur_dir;
  logic                    init_done;
  logic                    row_is_last;
  logic                    in_xfer, out_xfer;
  logic [1:0]              count;
  int unsigned             k;
  entry_t                  wr_entry, rd_entry;

  assign in_ready    = init_done && (count < 2'd2) && !abort;
  assign in_xfer     = in_valid && in_ready;
  assign out_valid   = (count != 2'd0);
  assign out_xfer    = out_valid && out_ready;
  assign row_is_last = (row_cnt == ROW_IDX_BITS'(NE - 1));
  // Row 0 of a matrix takes the live skew_dir; later rows use the value latched with row 0.
  assign cur_dir     = (state == IDLE) ? skew_dir : dir_q;

  always_comb begin
    k = 32'(row_cnt);
    if (cur_dir) k = (NE - 32'(row_cnt)) % NE;
    wr_entry.row       = in_row;
    wr_entry.shift_amt = SHIFT_AMT_BITS'(k * EW);
    wr_entry.row_idx   = row_cnt;
    wr_entry.last      = row_is_last;
  end

  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    dir_nxt     = dir_q;
    if (abort) begin
      state_nxt   = IDLE;
      row_cnt_nxt = '0;
    end else if (in_xfer) begin
      if (state == IDLE) dir_nxt = skew_dir;
      if (row_is_last) begin
        state_nxt   = IDLE;
        row_cnt_nxt = '0;
      end else begin
        state_nxt   = ACTIVE;
        row_cnt_nxt = row_cnt + ROW_IDX_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_cnt     <= '0;
      dir_q       <= 1'b0;
      init_done   <= 1'b0;
      matrix_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      row_cnt     <= row_cnt_nxt;
      dir_q       <= dir_nxt;
      init_done   <= 1'b1;
      matrix_done <= in_xfer && row_is_last;
    end
  end

  transpose_skew_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (2)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (abort),
    .push   (in_xfer),
    .pop    (out_xfer),
    .wr_dat (wr_entry),
    .rd_dat (rd_entry),
    .count  (count)
  );

  assign out_row       = rd_entry.row;
  assign out_shift_amt = rd_entry.shift_amt;
  assign out_row_idx   = rd_entry.row_idx;
  assign out_last      = rd_entry.last;
  assign busy          = (state == ACTIVE) || (count != 2'd0);
endmodule

// File: tb/tb_transpose_skew_feeder.sv
// Bench for transpose_skew_feeder: queue-based reference model, directed table and random traffic.
module tb_transpose_skew_feeder;
  localparam int NE = 16;
  localparam int EW = 32;
  localparam int TW = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_row = '0;
  logic          skew_dir = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] out_row;
  logic [8:0]    out_shift_amt;
  logic [3:0]    out_row_idx;
  logic          out_last;
  logic          matrix_done;
  logic          busy;

  transpose_skew_feeder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_row        (in_row),
    .skew_dir      (skew_dir),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_row       (out_row),
    .out_shift_amt (out_shift_amt),
    .out_row_idx   (out_row_idx),
    .out_last      (out_last),
    .matrix_done   (matrix_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] row;
    int            shift;
    int            idx;
    bit            last;
  } exp_t;

  typedef struct {
    bit iv; bit ordy; bit ab;
    bit rdy; bit ov; int idx; int shift; bit bsy;
  } vec_t;

  exp_t q[$];
  int   m_cnt = 0;
  bit   m_dir = 0;
  bit   exp_done = 0;
  int   tests = 0, fails = 0;
  int   done_cnt = 0, pushed = 0, popped = 0;
  logic s_rdy, s_ov, s_bsy;
  logic [3:0] s_idx;
  logic [8:0] s_shift;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, check settled outputs against the model, advance the model.
  task automatic cycle(input bit iv, input bit sd, input bit ordy, input bit ab);
    logic [TW-1:0] r;
    exp_t e;
    bit ixf, oxf;
    @(negedge clk);
    for (int w = 0; w < TW / 32; w++) r[w*32 +: 32] = $urandom;
    in_valid = iv; in_row = r; skew_dir = sd; out_ready = ordy; abort = ab;
    #1;
    s_rdy = in_ready; s_ov = out_valid; s_bsy = busy; s_idx = out_row_idx; s_shift = out_shift_amt;
    chk("in_ready", in_ready, (q.size() < 2) && !ab);
    chk("out_valid", out_valid, q.size() != 0);
    chk("busy", busy, (m_cnt != 0) || (q.size() != 0));
    chk("matrix_done", matrix_done, exp_done);
    if (matrix_done) done_cnt++;
    if (q.size() != 0) begin
      chk("out_row", out_row, q[0].row);
      chk("out_shift_amt", out_shift_amt, q[0].shift);
      chk("out_row_idx", out_row_idx, q[0].idx);
      chk("out_last", out_last, q[0].last);
    end
    ixf = iv && in_ready;
    oxf = out_valid && ordy;
    exp_done = 0;
    if (ab) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (oxf && q.size() != 0) begin
        void'(q.pop_front());
        popped++;
      end
      if (ixf) begin
        if (m_cnt == 0) m_dir = sd;
        e.row   = r;
        e.idx   = m_cnt;
        e.shift = (m_dir ? (NE - m_cnt) % NE : m_cnt) * EW;
        e.last  = (m_cnt == NE - 1);
        q.push_back(e);
        pushed++;
        exp_done = e.last;
        m_cnt = (m_cnt + 1) % NE;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 0; abort = 0; out_ready = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_matrix_done", matrix_done, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hold_out_valid", out_valid, 0);
    q.delete(); m_cnt = 0; m_dir = 0; exp_done = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    vec_t vt[12];
    int base, cyc;

    // Stall with 3 rows offered, release, then abort with 2 buffered after 5 rows.
    vt[0]  = '{1, 0, 0,  1, 0, 0, 0,  0};
    vt[1]  = '{1, 0, 0,  1, 1, 0, 0,  1};
    vt[2]  = '{1, 0, 0,  0, 1, 0, 0,  1};
    vt[3]  = '{1, 0, 0,  0, 1, 0, 0,  1};
    vt[4]  = '{1, 1, 0,  0, 1, 0, 0,  1};
    vt[5]  = '{1, 1, 0,  1, 1, 1, 32, 1};
    vt[6]  = '{1, 1, 0,  1, 1, 2, 64, 1};
    vt[7]  = '{1, 0, 0,  1, 1, 3, 96, 1};
    vt[8]  = '{0, 1, 1,  0, 1, 3, 96, 1};
    vt[9]  = '{1, 1, 0,  1, 0, 0, 0,  0};
    vt[10] = '{0, 1, 0,  1, 1, 0, 0,  1};
    vt[11] = '{0, 1, 0,  1, 0, 0, 0,  1};

    do_reset();

    // Back-to-back matrix, dir 0.
    done_cnt = 0;
    for (int i = 0; i < NE; i++) cycle(1, 0, 1, 0);
    repeat (2) cycle(0, 0, 1, 0);
    chk("dir0_done_pulses", done_cnt, 1);

    // Dir 1 latched on row 0; skew_dir wiggles afterwards.
    done_cnt = 0;
    for (int i = 0; i < NE; i++) cycle(1, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1, 0);
    repeat (2) cycle(0, 0, 1, 0);
    chk("dir1_done_pulses", done_cnt, 1);

    for (int i = 0; i < 12; i++) begin
      cycle(vt[i].iv, 0, vt[i].ordy, vt[i].ab);
      chk($sformatf("tbl%0d_in_ready", i), s_rdy, vt[i].rdy);
      chk($sformatf("tbl%0d_out_valid", i), s_ov, vt[i].ov);
      chk($sformatf("tbl%0d_busy", i), s_bsy, vt[i].bsy);
      if (vt[i].ov) begin
        chk($sformatf("tbl%0d_idx", i), s_idx, vt[i].idx);
        chk($sformatf("tbl%0d_shift", i), s_shift, vt[i].shift);
      end
    end

    // Reset mid-matrix with rows 8 and 9 buffered.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("full_before_reset", s_rdy, 0);
    do_reset();
    cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 0);
    chk("post_reset_idx", s_idx, 0);
    chk("post_reset_shift", s_shift, 0);
    chk("post_reset_valid", s_ov, 1);

    // Random traffic over 64 matrices.
    do_reset();
    done_cnt = 0;
    base = pushed;
    popped = 0;
    cyc = 0;
    while ((pushed - base) < 64 * NE && cyc < 20000) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, 0);
      cyc++;
    end
    chk("rand_rows_accepted", pushed - base, 64 * NE);
    repeat (4) cycle(0, 0, 1, 0);
    chk("rand_done_pulses", done_cnt, 64);
    chk("rand_rows_emitted", popped, 64 * NE);
    chk("rand_queue_empty", q.size(), 0);
    chk("rand_idle_busy", s_bsy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/transpose_skew_feeder.md
TRANSPOSE_SKEW_FEEDER -- requirements
Module: transpose_skew_feeder

Interface
REQ-001 Parameter TOTAL_WIDTH, default 512: row width in bits.
REQ-002 Parameter ELEM_WIDTH, default 32: matrix element width in bits; TOTAL_WIDTH SHALL be an exact multiple of it.
REQ-003 Parameter NUM_ELEMS, default TOTAL_WIDTH/ELEM_WIDTH (16): rows per matrix and elements per row.
REQ-004 Parameter SHIFT_AMT_BITS, default $clog2(TOTAL_WIDTH): shift-amount width.
REQ-005 Parameter ROW_IDX_BITS, default $clog2(NUM_ELEMS): row-index width.
REQ-006 clk  input  1  single clock; all state is updated on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 abort  input  1  synchronous clear of the current matrix and all buffered rows.
REQ-009 in_valid  input  1  in_row is presented.
REQ-010 in_ready  output  1  feeder accepts in_row this cycle.
REQ-011 in_row  input  TOTAL_WIDTH  one matrix row, element 0 in bits [ELEM_WIDTH-1:0].
REQ-012 skew_dir  input  1  0 = skew row i right by i elements; 1 = skew by (NUM_ELEMS-i) mod NUM_ELEMS elements.
REQ-013 out_valid  output  1  out_* fields hold a valid row.
REQ-014 out_ready  input  1  downstream circular-shift stage consumes the row.
REQ-015 out_row  output  TOTAL_WIDTH  buffered row, unmodified.
REQ-016 out_shift_amt  output  SHIFT_AMT_BITS  bit shift amount for the row.
REQ-017 out_row_idx  output  ROW_IDX_BITS  row index within the matrix.
REQ-018 out_last  output  1  row is row NUM_ELEMS-1.
REQ-019 matrix_done  output  1  one-cycle pulse when the last row of a matrix is accepted at the input.
REQ-020 busy  output  1  high while a matrix is partially received or the FIFO is non-empty.

Function
REQ-021 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-022 Rows SHALL be buffered in a 2-entry FIFO holding {row, shift_amt, row_idx, last}; in_ready = (count < 2) && !abort.
REQ-023 out_valid SHALL equal (count != 0); out_* SHALL reflect the FIFO head; latency from input transfer to out_valid SHALL be 1 cycle when the FIFO is empty.
REQ-024 A simultaneous input and output transfer at count 1 or 2 SHALL leave count unchanged and preserve order.
REQ-025 out_* SHALL remain stable while out_valid && !out_ready.
REQ-026 The state machine SHALL have states IDLE (row counter 0, no matrix open) and ACTIVE (rows 1..NUM_ELEMS-1 pending).
REQ-027 IDLE -> ACTIVE on an input transfer of row 0; skew_dir SHALL be latched on that transfer and used for the whole matrix.
REQ-028 The row counter SHALL increment on each input transfer and wrap from NUM_ELEMS-1 to 0 with the state returning to IDLE.
REQ-029 For NUM_ELEMS == 1, every row SHALL be row 0 and last, and the state SHALL stay IDLE.
REQ-030 Shift amount SHALL be k*ELEM_WIDTH with k = i (dir 0) or (NUM_ELEMS-i) mod NUM_ELEMS (dir 1), computed at full width without truncation, so it is always < TOTAL_WIDTH.
REQ-031 matrix_done SHALL pulse the cycle after the input transfer of row NUM_ELEMS-1.
REQ-032 abort SHALL empty the FIFO, zero the counter, enter IDLE, and block input transfer that cycle; an output transfer in the same cycle is discarded.
REQ-033 busy = (state == ACTIVE) || (count != 0).

Reset
REQ-034 While rst_n is low: FIFO count 0, row counter 0, state IDLE, latched dir 0, out_valid 0, matrix_done 0, busy 0, in_ready 0.
REQ-035 After rst_n deassertion, in_ready SHALL be 1 from the first clock edge.
REQ-036 Reset asserted mid-matrix SHALL discard all buffered rows; the next accepted row is row 0.

Verification
REQ-037 Defaults, skew_dir=0, out_ready=1, 16 back-to-back rows -> out_row_idx 0..15 and out_shift_amt 0,32,...,480; out_last only on idx 15; one matrix_done.
REQ-038 skew_dir=1, 16 rows -> shift amounts 0,480,448,...,32; toggling skew_dir mid-matrix has no effect until the next row 0.
REQ-039 out_ready=0, 3 rows offered -> 2 accepted, in_ready=0, head stable; raise out_ready -> rows emitted in order and the third is accepted.
REQ-040 abort after 5 rows with 2 buffered -> out_valid=0 next cycle, busy=0; the next row gets idx 0 and shift 0.
REQ-041 rst_n low after row 9 with FIFO full -> all outputs at reset values; resume with row idx 0.
REQ-042 Random in_valid/out_ready over 64 matrices -> no loss or duplication, order preserved, 64 matrix_done pulses.
